restoring_divider_4bit: RTL

Multi-cycle unsigned restoring divider: the inverse of the combinational add/subtract datapath. It computes quotient and remainder of two WIDTH-bit operands, one trial subtraction per clock. It sits beside the adder/subtractor in the lab datapath as the sequential arithmetic unit and uses a start/done handshake toward its driver.

---
 rtl/restoring_divider_pkg.sv | 18 +
 rtl/restoring_divider_4bit_if.sv | 26 ++
 rtl/restoring_divider_4bit_trial_subtractor.sv | 24 ++
 rtl/restoring_divider_4bit.sv | 120 ++++++++++++
 4 files changed

// File: rtl/restoring_divider_pkg.sv
// Shared types and sizing for the sequential restoring divider.
// States, default operand width and the iteration-counter width helper.
package restoring_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

  // Counter must hold the value WIDTH, hence the +1.
  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/restoring_divider_4bit_if.sv
// Start/done request bus between a driver (master) and the divider (slave).
// Operands travel with start; results, busy, done and div_by_zero come back.
interface restoring_divider_4bit_if
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/restoring_divider_4bit_trial_subtractor.sv
// Combinational W-bit ripple subtractor (a + ~b + 1); zero latency, no handshake.
// borrow is the inverted carry out, i.e. set when a < b.
module trial_subtractor #(
  parameter int W = 5
) (
  input  logic [W-1:0] a_dat,
  input  logic [W-1:0] b_dat,
  output logic [W-1:0] diff_dat,
  output logic         borrow
);

  logic carry;

  always_comb begin
    carry    = 1'b1;
    diff_dat = '0;
    for (int i = 0; i < W; i++) begin
      diff_dat[i] = a_dat[i] ^ ~b_dat[i] ^ carry;
      carry       = (a_dat[i] & ~b_dat[i]) | (carry & (a_dat[i] ^ ~b_dat[i]));
    end
    borrow = ~carry;
  end

endmodule

// File: rtl/restoring_divider_4bit.sv
// Unsigned restoring divider, one trial subtraction per clock: WIDTH+1 cycles per op.
// start is ignored while busy (no queuing); divide-by-zero completes in one cycle.
module restoring_divider_4bit
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                     clk,
  input logic                     reset,
  restoring_divider_4bit_if.slave bus
);

  localparam int CW = count_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    count_q, count_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH:0]   trial;
  logic             borrow;

  assign r_shift = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

  trial_subtractor #(.W(WIDTH + 1)) u_trial (
    .a_dat    ({1'b0, r_shift}),
    .b_dat    ({1'b0, dvs_q}),
    .diff_dat (trial),
    .borrow   (borrow)
  );

  always_comb begin
    r_next = r_shift;
    q_next = {q_q[WIDTH-2:0], 1'b0};
    if (!borrow) begin
      r_next = trial[WIDTH-1:0];
      q_next = {q_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    count_d = count_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          dvs_d = bus.divisor;
          if (bus.divisor != '0) begin
            r_d     = '0;
            q_d     = bus.dividend;
            count_d = '0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end else begin
            quo_d   = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        r_d     = r_next;
        q_d     = q_next;
        count_d = count_q + CW'(1);
        // Last iteration: publish the freshly computed Q/R directly.
        if (count_q == CW'(WIDTH - 1)) begin
          quo_d   = q_next;
          rem_d   = r_next;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      count_q <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      count_q <= count_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.div_by_zero = dbz_q;

endmodule
